// File: rtl/dmem_pkg.sv
// Shared types for the data-memory write buffer: buffer entry layout,
// drain-FSM states and buffer geometry defaults.
package dmem_pkg;

  localparam int WB_ADDR_W = 11;
  localparam int WB_DEPTH  = 4;
  localparam int WB_PTR_W  = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [31:0]          data;
  } wb_entry_t;

  typedef enum logic {
    IDLE,
    BUSY
  } drain_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Backing word RAM: synchronous write port, combinational read port.
// Contents are never reset.
module dmem_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory with a FIFO write buffer in front of a slow backing RAM.
// Optional macro DMEM_WBUF_COALESCE_EN merges stores into matching non-head entries.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DEPTH_WB = WB_DEPTH,
  parameter int WR_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_Wena,
  input  logic              DM_Rena,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [31:0]       DM_wdata,
  output logic [31:0]       DM_rdata,
  output logic              dm_stall,
  output logic              wb_empty
);

  localparam int PTR_W = WB_PTR_W;
  localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(WR_LAT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH_WB);

  wb_entry_t        buf_q [DEPTH_WB];
  wb_entry_t        drain_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  drain_state_t     state_q;
  logic [LAT_W-1:0] lat_q;

  logic             full, enq, pop, coal_hit;
  logic             fwd_hit;
  logic [31:0]      fwd_data, ram_rdata;
  logic [PTR_W-1:0] idx;
`ifdef DMEM_WBUF_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;
`endif

  // Scan oldest to youngest so the last match wins; the head is never a merge
  // target because it is either being drained or about to be latched.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
`ifdef DMEM_WBUF_COALESCE_EN
    coal_hit = 1'b0;
    coal_idx = head_q;
`endif
    for (int i = 0; i < DEPTH_WB; i++) begin
      idx = head_q + PTR_W'(i);
      if ((PTR_W+1)'(i) < count_q && buf_q[idx].addr == DM_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_q[idx].data;
`ifdef DMEM_WBUF_COALESCE_EN
        if (i != 0) begin
          coal_hit = 1'b1;
          coal_idx = idx;
        end
`endif
      end
    end
  end

`ifndef DMEM_WBUF_COALESCE_EN
  assign coal_hit = 1'b0;
`endif

  assign full     = (count_q == CNT_FULL);
  assign dm_stall = DM_Wena & full & ~coal_hit;
  assign enq      = DM_Wena & ~dm_stall & ~coal_hit;
  assign pop      = (state_q == BUSY) && (lat_q == '0);
  assign wb_empty = (count_q == '0) && (state_q == IDLE);
  assign DM_rdata = DM_Rena ? (fwd_hit ? fwd_data : ram_rdata) : '0;

  always_ff @(posedge clk) begin
    if (enq) buf_q[tail_q] <= '{addr: DM_addr, data: DM_wdata};
`ifdef DMEM_WBUF_COALESCE_EN
    if (DM_Wena && coal_hit) buf_q[coal_idx].data <= DM_wdata;
`endif
    if (state_q == IDLE && count_q != '0) drain_q <= buf_q[head_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      case (state_q)
        IDLE: if (count_q != '0) begin
          state_q <= BUSY;
          lat_q   <= LAT_INIT;
        end
        BUSY: if (lat_q == '0) state_q <= IDLE;
              else lat_q <= lat_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst abandons a write whose final cycle coincides with reset.
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (pop & ~rst),
    .waddr (drain_q.addr),
    .wdata (drain_q.data),
    .raddr (DM_addr),
    .rdata (ram_rdata)
  );

endmodule
